// File: rtl/usbh_tx_sequencer_if.sv
// Bundle of the sequencer's control, TX-FIFO and ULPI TX signals.
// The slave modport is the sequencer's view; master is the SIE/FIFO/PHY side.
interface usbh_tx_sequencer_if #(
    parameter int LEN_W = 7
);
    logic             start_i;
    logic [3:0]       pid_i;
    logic             data_en_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [7:0]       fifo_data_i;
    logic             fifo_empty_i;
    logic             fifo_pop_o;
    logic             fifo_flush_o;
    logic [7:0]       tx_data_o;
    logic             tx_valid_o;
    logic             tx_ready_i;
    logic             tx_last_o;

    modport slave (
        input  start_i, pid_i, data_en_i, len_i, fifo_data_i, fifo_empty_i, tx_ready_i,
        output busy_o, done_o, err_o, fifo_pop_o, fifo_flush_o, tx_data_o, tx_valid_o, tx_last_o
    );

    modport master (
        output start_i, pid_i, data_en_i, len_i, fifo_data_i, fifo_empty_i, tx_ready_i,
        input  busy_o, done_o, err_o, fifo_pop_o, fifo_flush_o, tx_data_o, tx_valid_o, tx_last_o
    );
endinterface

// File: rtl/usbh_tx_sequencer.sv
// USB host transmit sequencer: PID byte, optional FIFO payload, CRC16 trailer,
// streamed to the ULPI TX path with valid/ready handshaking.
module usbh_tx_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    usbh_tx_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_ERR
    } state_t;

    state_t           state_q;
    logic [3:0]       pid_q;
    logic             data_en_q;
    logic [LEN_W-1:0] cnt_q;
    logic [15:0]      crc_q;
    logic             done_q;

    logic [15:0]      crc_chain [0:8];
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             xfer;

    // Reflected CRC-16/USB, one bit per stage, LSB of the byte first.
    assign crc_chain[0] = crc_q;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc
            assign crc_chain[gi+1] = (crc_chain[gi][0] ^ bus.fifo_data_i[gi])
                                   ? ({1'b0, crc_chain[gi][15:1]} ^ 16'hA001)
                                   : {1'b0, crc_chain[gi][15:1]};
        end
    endgenerate

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        case (state_q)
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
                tx_last  = ~data_en_q;
            end
            S_DATA: begin
                tx_valid = ~bus.fifo_empty_i;
                tx_data  = bus.fifo_empty_i ? 8'h00 : bus.fifo_data_i;
            end
            S_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[7:0];
            end
            S_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[15:8];
                tx_last  = 1'b1;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign xfer             = tx_valid & bus.tx_ready_i;
    assign bus.tx_valid_o   = tx_valid;
    assign bus.tx_data_o    = tx_data;
    assign bus.tx_last_o    = tx_last;
    assign bus.fifo_pop_o   = (state_q == S_DATA) & xfer;
    assign bus.fifo_flush_o = (state_q == S_ERR);
    assign bus.err_o        = (state_q == S_ERR);
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pid_q     <= 4'h0;
            data_en_q <= 1'b0;
            cnt_q     <= '0;
            crc_q     <= 16'hFFFF;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    crc_q <= 16'hFFFF;
                    if (bus.start_i) begin
                        pid_q     <= bus.pid_i;
                        data_en_q <= bus.data_en_i;
                        cnt_q     <= bus.len_i;
                        if (bus.data_en_i && (bus.len_i > LEN_W'(MAX_LEN))) begin
                            state_q <= S_ERR;
                        end else begin
                            state_q <= S_PID;
                        end
                    end
                end
                S_PID: begin
                    if (xfer) begin
                        if (!data_en_q) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q <= S_CRC_LO;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // An empty FIFO mid-payload aborts the packet.
                    if (bus.fifo_empty_i) begin
                        state_q <= S_ERR;
                    end else if (bus.tx_ready_i) begin
                        crc_q <= crc_chain[8];
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= S_CRC_LO;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (bus.tx_ready_i) begin
                        state_q <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (bus.tx_ready_i) begin
                        state_q <= S_IDLE;
                        crc_q   <= 16'hFFFF;
                        done_q  <= 1'b1;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    crc_q   <= 16'hFFFF;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usbh_tx_sequencer.sv
// Directed bench for usbh_tx_sequencer: handshake, data, zero-length,
// backpressure, underrun, length error and mid-packet reset.
module tb_usbh_tx_sequencer;
    localparam int LEN_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usbh_tx_sequencer_if #(.LEN_W(LEN_W)) bus();

    usbh_tx_sequencer #(.MAX_LEN(64), .LEN_W(LEN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // First-word fall-through FIFO stand-in
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr   = 0;
    int         rd_ptr   = 0;
    logic       tb_flush = 1'b0;

    assign bus.fifo_empty_i = (rd_ptr == wr_ptr);
    assign bus.fifo_data_i  = fifo_mem[rd_ptr % 256];

    always @(posedge clk) begin
        if (tb_flush || bus.fifo_flush_o) rd_ptr <= wr_ptr;
        else if (bus.fifo_pop_o)          rd_ptr <= rd_ptr + 1;
    end

    // Transfer capture and event counters
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    int         n_pop = 0, n_done = 0, n_err = 0, n_flush = 0;
    int         stall_bad = 0, pop_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_valid_o && bus.tx_ready_i) begin
            cap_data.push_back(bus.tx_data_o);
            cap_last.push_back(bus.tx_last_o);
        end
        if (bus.fifo_pop_o) n_pop <= n_pop + 1;
        if (bus.fifo_pop_o && (bus.fifo_empty_i || !(bus.tx_valid_o && bus.tx_ready_i)))
            pop_bad <= pop_bad + 1;
        if (bus.done_o)       n_done  <= n_done + 1;
        if (bus.err_o)        n_err   <= n_err + 1;
        if (bus.fifo_flush_o) n_flush <= n_flush + 1;
        if (prev_stall && !rst &&
            (!bus.tx_valid_o || bus.tx_data_o != prev_data || bus.tx_last_o != prev_last))
            stall_bad <= stall_bad + 1;
        prev_stall <= bus.tx_valid_o && !bus.tx_ready_i;
        prev_data  <= bus.tx_data_o;
        prev_last  <= bus.tx_last_o;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_bytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr % 256] = first + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic set_data_exp();
        exp_q = {8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'hC8, 8'hB4};
    endtask

    function automatic logic [14:0] out_vec();
        return {bus.busy_o, bus.done_o, bus.err_o, bus.fifo_pop_o, bus.fifo_flush_o,
                bus.tx_valid_o, bus.tx_last_o, bus.tx_data_o};
    endfunction

    // Called at posedge+1; start is asserted for this one cycle (cycle 0).
    task automatic run_packet(input string name, input logic [3:0] pid, input logic den,
                              input logic [LEN_W-1:0] len, input logic bp,
                              input int exp_end, input int exp_pops, input int exp_err);
        int base, p0, d0, e0, f0, s0, b0, end_cyc, got_n, lasts;
        logic [31:0] got;
        base = cap_data.size();
        p0 = n_pop; d0 = n_done; e0 = n_err; f0 = n_flush; s0 = stall_bad; b0 = pop_bad;
        end_cyc = -1;
        bus.start_i = 1'b1; bus.pid_i = pid; bus.data_en_i = den; bus.len_i = len;
        bus.tx_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.pid_i = 4'h0; bus.data_en_i = 1'b0; bus.len_i = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check({name, ":first_valid"}, 32'(bus.tx_valid_o), 32'(exp_q.size() > 0));
                if (exp_q.size() > 0) check({name, ":first_byte"}, 32'(bus.tx_data_o), 32'(exp_q[0]));
            end
            if (bus.done_o || bus.err_o) begin
                end_cyc = cyc;
                check({name, ":busy_at_end"}, 32'(bus.busy_o), 32'(exp_err));
                check({name, ":valid_at_end"}, 32'(bus.tx_valid_o), 32'd0);
                break;
            end
            @(posedge clk); #1;
            bus.tx_ready_i = bp ? logic'(((cyc + 1) % 2) == 1) : 1'b1;
        end
        bus.tx_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check({name, ":end_cycle"}, 32'(end_cyc), 32'(exp_end));
        got_n = cap_data.size() - base;
        check({name, ":byte_count"}, 32'(got_n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < got_n) ? 32'(cap_data[base + i]) : 32'hDEAD;
            check($sformatf("%s:byte%0d", name, i), got, 32'(exp_q[i]));
        end
        lasts = 0;
        for (int i = 0; i < got_n; i++) if (cap_last[base + i]) lasts++;
        check({name, ":last_count"}, 32'(lasts), 32'(exp_err ? 0 : 1));
        if (!exp_err && got_n > 0) check({name, ":last_on_final"}, 32'(cap_last[base + got_n - 1]), 32'd1);
        check({name, ":pops"},      32'(n_pop - p0),      32'(exp_pops));
        check({name, ":done"},      32'(n_done - d0),     32'(exp_err ? 0 : 1));
        check({name, ":err"},       32'(n_err - e0),      32'(exp_err));
        check({name, ":flush"},     32'(n_flush - f0),    32'(exp_err));
        check({name, ":stall_bad"}, 32'(stall_bad - s0),  32'd0);
        check({name, ":pop_bad"},   32'(pop_bad - b0),    32'd0);
        $display("packet %s: %0d bytes, end cycle %0d", name, got_n, end_cyc);
    endtask

    initial begin
        int d0;
        bus.start_i = 1'b0; bus.pid_i = 4'h0; bus.data_en_i = 1'b0; bus.len_i = '0;
        bus.tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(out_vec()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", 32'(out_vec()), 32'd0);

        exp_q = {8'hD2};
        run_packet("handshake", 4'h2, 1'b0, 7'd0, 1'b0, 2, 0, 0);

        push_bytes(9, 8'h31);
        set_data_exp();
        run_packet("data9", 4'h3, 1'b1, 7'd9, 1'b0, 13, 9, 0);

        exp_q = {8'h4B, 8'h00, 8'h00};
        run_packet("zero_len", 4'hB, 1'b1, 7'd0, 1'b0, 4, 0, 0);

        push_bytes(9, 8'h31);
        set_data_exp();
        run_packet("backpressure", 4'h3, 1'b1, 7'd9, 1'b1, 24, 9, 0);

        push_bytes(3, 8'h31);
        exp_q = {8'hC3, 8'h31, 8'h32, 8'h33};
        run_packet("underrun", 4'h3, 1'b1, 7'd5, 1'b0, 6, 3, 1);
        check("underrun_fifo_empty", 32'(bus.fifo_empty_i), 32'd1);

        exp_q = {};
        run_packet("len65", 4'h3, 1'b1, 7'd65, 1'b0, 1, 0, 1);

        // Reset while streaming payload, then a normal packet
        push_bytes(9, 8'h31);
        d0 = n_done;
        bus.start_i = 1'b1; bus.pid_i = 4'h3; bus.data_en_i = 1'b1; bus.len_i = 7'd9;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_in_data", 32'(bus.fifo_pop_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", 32'(out_vec()), 32'd0);
        rst = 1'b0;
        tb_flush = 1'b1;
        @(posedge clk); #1;
        tb_flush = 1'b0;
        check("post_reset_outputs", 32'(out_vec()), 32'd0);
        check("post_reset_no_done", 32'(n_done - d0), 32'd0);
        $display("packet reset_mid_data: aborted by reset");
        push_bytes(9, 8'h31);
        set_data_exp();
        run_packet("after_reset", 4'h3, 1'b1, 7'd9, 1'b0, 13, 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
